// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : enc_pkg
//  Purpose  : Shared types, mode constants and the quadrature step classifier
//             for the encoder revolution analyser.
//  Revision : 1.0  initial release
// ============================================================================
package enc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_FWD     = 2'd1,
        STEP_REV     = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_t;

    localparam logic [1:0] MODE_X1 = 2'b00;
    localparam logic [1:0] MODE_X2 = 2'b01;
    localparam logic [1:0] MODE_X4 = 2'b10;

    // Forward order of {A,B} is 00 -> 10 -> 11 -> 01 -> 00; a double-bit
    // change has no defined direction and is flagged illegal.
    function automatic step_t classify_step(input logic [1:0] prev_ab,
                                            input logic [1:0] cur_ab);
        step_t step;
        step = STEP_NONE;
        if (prev_ab != cur_ab) begin
            if ((prev_ab ^ cur_ab) == 2'b11) begin
                step = STEP_ILLEGAL;
            end else begin
                case (prev_ab)
                    2'b00:   step = (cur_ab == 2'b10) ? STEP_FWD : STEP_REV;
                    2'b10:   step = (cur_ab == 2'b11) ? STEP_FWD : STEP_REV;
                    2'b11:   step = (cur_ab == 2'b01) ? STEP_FWD : STEP_REV;
                    default: step = (cur_ab == 2'b00) ? STEP_FWD : STEP_REV;
                endcase
            end
        end
        return step;
    endfunction

endpackage
`default_nettype wire

// File: rtl/enc_quad_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : enc_quad_decoder
//  Purpose  : Synchronises A/B/Z, classifies quadrature steps, produces the
//             mode-dependent count event, direction, illegal flag and Z rise.
//  Revision : 1.0  initial release
// ============================================================================
module enc_quad_decoder
    import enc_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       AIn,
    input  logic       BIn,
    input  logic       ZIn,
    input  logic [1:0] Mode,
    output logic       cnt_evt,
    output logic       dir,
    output logic       illegal,
    output logic       z_rise
);

    // Bit order in all three stages is {A, B, Z}
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] r_dly;
    step_t      w_step;
    logic       w_valid;
    logic       w_a_edge;
    logic       w_a_rise;

    // Two-flop synchroniser followed by a delay stage for edge comparison
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_dly   <= '0;
        end else begin
            r_sync1 <= {AIn, BIn, ZIn};
            r_sync2 <= r_sync1;
            r_dly   <= r_sync2;
        end
    end

    // Step classification and per-mode count event selection
    always_comb begin
        w_step   = classify_step(r_dly[2:1], r_sync2[2:1]);
        w_valid  = (w_step == STEP_FWD) || (w_step == STEP_REV);
        w_a_edge = w_valid && (r_dly[2] != r_sync2[2]);
        w_a_rise = w_a_edge && r_sync2[2];
        case (Mode)
            MODE_X1: cnt_evt = w_a_rise;
            MODE_X2: cnt_evt = w_a_edge;
            default: cnt_evt = w_valid;
        endcase
        illegal = (w_step == STEP_ILLEGAL);
        z_rise  = r_sync2[0] & ~r_dly[0];
    end

    // Direction follows the most recent valid step; illegal steps leave it
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            dir <= 1'b0;
        end else if (w_step == STEP_FWD) begin
            dir <= 1'b1;
        end else if (w_step == STEP_REV) begin
            dir <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/enc_rev_analyser.sv
`default_nettype none
// ============================================================================
//  Module   : enc_rev_analyser
//  Purpose  : Measures counts per revolution over N Z-to-Z revolutions,
//             tracks min/max/last PPR, run time and quadrature errors, and
//             streams a timestamp per counted edge to a capture RAM port.
//  Revision : 1.0  initial release
// ============================================================================
module enc_rev_analyser
    import enc_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int TIME_W = 32,
    parameter int ADDR_W = 14,
    parameter int NREV_W = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              AIn,
    input  logic              BIn,
    input  logic              ZIn,
    input  logic              Start,
    input  logic              Abort,
    input  logic [1:0]        Mode,
    input  logic [NREV_W-1:0] NRev,
    output logic [CNT_W-1:0]  PPR,
    output logic [CNT_W-1:0]  PPRMin,
    output logic [CNT_W-1:0]  PPRMax,
    output logic [TIME_W-1:0] RevTime,
    output logic [CNT_W-1:0]  QuadErr,
    output logic              Dir,
    output logic              Busy,
    output logic              Done,
    output logic              WrEn,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [TIME_W-1:0] WrData,
    output logic              Ovf
);

    localparam logic [CNT_W-1:0]  c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [TIME_W-1:0] c_TIME_MAX = {TIME_W{1'b1}};
    localparam logic [ADDR_W-1:0] c_ADDR_MAX = {ADDR_W{1'b1}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_start_s1, r_start_s2, r_start_dly;
    logic              r_abort_s1, r_abort_s2;
    logic              w_cnt_evt, w_illegal, w_z_rise;
    logic              w_start_rise, w_abort, w_run, w_count, w_close, w_last_rev;
    logic [CNT_W-1:0]  r_ctr, w_ctr_inc, w_ctr_close;
    logic [NREV_W-1:0] r_rev, w_rev_nxt, w_nrev_eff;
    logic [TIME_W-1:0] r_timer, w_timer_inc;
    logic [ADDR_W-1:0] r_ptr;

    enc_quad_decoder u_dec (
        .Clk     (Clk),
        .Rst     (Rst),
        .AIn     (AIn),
        .BIn     (BIn),
        .ZIn     (ZIn),
        .Mode    (Mode),
        .cnt_evt (w_cnt_evt),
        .dir     (Dir),
        .illegal (w_illegal),
        .z_rise  (w_z_rise)
    );

    // Control inputs share the pin path depth of the encoder signals
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_start_s1  <= 1'b0;
            r_start_s2  <= 1'b0;
            r_start_dly <= 1'b0;
            r_abort_s1  <= 1'b0;
            r_abort_s2  <= 1'b0;
        end else begin
            r_start_s1  <= Start;
            r_start_s2  <= r_start_s1;
            r_start_dly <= r_start_s2;
            r_abort_s1  <= Abort;
            r_abort_s2  <= r_abort_s1;
        end
    end

    // Shared qualifiers; abort suppresses counting and closing in its cycle
    always_comb begin
        w_start_rise = r_start_s2 & ~r_start_dly;
        w_abort      = r_abort_s2;
        w_nrev_eff   = (NRev == '0) ? NREV_W'(1) : NRev;
        w_rev_nxt    = r_rev + NREV_W'(1);
        w_last_rev   = (w_rev_nxt == w_nrev_eff);
        w_run        = (r_state == ST_RUN) && !w_abort;
        w_count      = w_run && w_cnt_evt;
        w_close      = w_run && w_z_rise;
        w_ctr_inc    = (r_ctr == c_CNT_MAX) ? r_ctr : r_ctr + CNT_W'(1);
        w_ctr_close  = w_count ? w_ctr_inc : r_ctr;
        w_timer_inc  = (r_timer == c_TIME_MAX) ? r_timer : r_timer + TIME_W'(1);
    end

    // FSM state register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start_rise) w_state_nxt = ST_ARM;
            ST_ARM: begin
                if (w_abort)       w_state_nxt = ST_IDLE;
                else if (w_z_rise) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_abort)                    w_state_nxt = ST_IDLE;
                else if (w_z_rise && w_last_rev) w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        Busy = (r_state == ST_ARM) || (r_state == ST_RUN);
        Done = (r_state == ST_DONE);
    end

    // Measurement datapath and capture write port
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            PPR     <= '0;
            PPRMin  <= '0;
            PPRMax  <= '0;
            RevTime <= '0;
            QuadErr <= '0;
            WrEn    <= 1'b0;
            WrAddr  <= '0;
            WrData  <= '0;
            Ovf     <= 1'b0;
            r_ctr   <= '0;
            r_rev   <= '0;
            r_timer <= '0;
            r_ptr   <= '0;
        end else begin
            WrEn <= 1'b0;
            if (r_state == ST_IDLE && w_start_rise) begin
                QuadErr <= '0;
                WrAddr  <= '0;
                r_ptr   <= '0;
                Ovf     <= 1'b0;
                PPRMin  <= c_CNT_MAX;
                PPRMax  <= '0;
            end
            if ((r_state == ST_ARM || r_state == ST_RUN) && w_illegal && QuadErr != c_CNT_MAX) begin
                QuadErr <= QuadErr + CNT_W'(1);
            end
            if (r_state == ST_ARM && !w_abort && w_z_rise) begin
                r_timer <= '0;
                r_ctr   <= '0;
                r_rev   <= '0;
            end
            if (w_run) begin
                r_timer <= w_timer_inc;
            end
            if (w_count) begin
                r_ctr <= w_ctr_inc;
                if (!Ovf) begin
                    WrEn   <= 1'b1;
                    WrData <= r_timer;
                    WrAddr <= r_ptr;
                    // Address sticks at the top entry instead of wrapping
                    if (r_ptr == c_ADDR_MAX) Ovf <= 1'b1;
                    else                     r_ptr <= r_ptr + ADDR_W'(1);
                end
            end
            // A count event coincident with Z is folded into the closing revolution
            if (w_close) begin
                PPR   <= w_ctr_close;
                r_ctr <= '0;
                r_rev <= w_rev_nxt;
                if (w_ctr_close < PPRMin) PPRMin <= w_ctr_close;
                if (w_ctr_close > PPRMax) PPRMax <= w_ctr_close;
                // Timer value including this cycle: clocks between arming Z and final Z
                if (w_last_rev) RevTime <= w_timer_inc;
            end
        end
    end

endmodule
`default_nettype wire
